bmp_frame_serializer: RTL and testbench
=======================================

Name: bmp_frame_serializer

Overview:
Parametrised successor to the simulation-only BMP writer. It is synthesizable: it captures one frame of RGB888 pixels, arriving PIX_PER_BEAT pixels per beat, into an internal frame buffer. It then streams a complete 24-bit BMP file (header plus bottom-up, BGR, row-padded pixel data) as a byte stream with a valid/ready handshake. It sits at the tail of the image-processing pipeline and feeds a file/DMA/UART sink.

Parameters:
WIDTH, 100, image width in pixels; must be a multiple of PIX_PER_BEAT.
HEIGHT, 100, image height in rows; must be at least 1.
PIX_PER_BEAT, 2, pixels per input beat; legal values are 1, 2, 4.
HEADER_BYTES, 54, BMP header length; fixed, not overridable.

Ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous reset, active-high
hsync  in  1  input beat valid
sof  in  1  start of frame; qualified by hsync
DATA_IN  in  24*PIX_PER_BEAT  pixel p at [24p+23:24p] as {R[23:16],G[15:8],B[7:0]}; pixel 0 is leftmost
in_ready  out  1  high only in CAPTURE
out_byte  out  8  BMP byte
out_valid  out  1  out_byte valid
out_ready  in  1  sink accepts
out_last  out  1  final byte of file; qualified by out_valid
Write_Done  out  1  one-cycle pulse after the last byte transfers
frame_err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (asynchronous, active-high): state=CAPTURE, column/row/byte counters=0, in_ready=1, out_valid=0, out_last=0, out_byte=0, Write_Done=0, frame_err=0. The buffer is not cleared.
- Derived values:
  - ROW_BYTES = 3*WIDTH rounded up to a multiple of 4.
  - PAD = ROW_BYTES - 3*WIDTH.
  - IMG_SIZE = ROW_BYTES*HEIGHT.
  - FILE_SIZE = 54 + IMG_SIZE.
  - All are computed at elaboration, 32-bit little-endian.
- Input beats are accepted when hsync && in_ready.
  - Column counter m runs 0..WIDTH/PIX_PER_BEAT-1. On wrap, m goes to 0 and row l increments.
  - The beat is stored at buffer row HEIGHT-1-l, pixels m*PIX_PER_BEAT onward, so the bottom row is first in memory.
- sof && hsync in CAPTURE: the beat is taken as row 0, column 0, and counters restart. If (l,m) was not (0,0), frame_err pulses that same cycle.
- hsync while in_ready=0: the beat is dropped and frame_err pulses. sof is ignored outside CAPTURE.
- The last beat (l=HEIGHT-1, m=max) is accepted. The next cycle is state HEADER, with in_ready=0 and out_valid=1.
- HEADER: emits bytes 0..53.
  - Byte values: 0x42 'B', 0x4D 'M', FILE_SIZE[4], 0[4], 54[4], 40[4], WIDTH[4], HEIGHT[4], 1[2], 24[2], 0[4], IMG_SIZE[4], 2835[4], 2835[4], 0[4], 0[4].
  - Multi-byte fields are little-endian.
- PIXELS: emits buffer rows in memory order. Each row is B,G,R per pixel, left to right, then PAD zero bytes.
- Handshake:
  - A byte transfers on out_valid && out_ready.
  - Once out_valid is high, out_byte, out_last and out_valid are held until transfer.
  - out_ready low stalls indefinitely with no loss.
  - Bubbles between bytes are permitted, but at most 1 idle cycle per byte (synchronous buffer read allowed).
- out_last is high exactly with byte FILE_SIZE-1. After it transfers, the next cycle gives Write_Done=1 for one cycle, out_valid=0, state=CAPTURE and in_ready=1.
- The buffer is WIDTH*HEIGHT entries of 24 bits. Counter widths are $clog2-sized; no overflow is possible at legal parameters.
- Reset mid-operation aborts capture or streaming immediately and returns to the reset state. Partial output is not completed.

Test Plan:
1. WIDTH=4, HEIGHT=2, PPB=2, out_ready=1; send 4 beats.
   -> 78 bytes total.
   -> Bytes [0..5] = 42 4D 4E 00 00 00; [18]=04, [22]=02, [26]=01, [28]=18, [34]=18.
   -> out_last on byte 77; Write_Done 1 cycle later.
2. Same config; row0 pixels = 0x010203·i, row1 = 0x111213·i.
   -> Byte 54 onward is row1 first: 13 12 11 …; row0 follows.
3. WIDTH=5, HEIGHT=2, PPB=1.
   -> ROW_BYTES=16; FILE_SIZE=86 (byte[2]=0x56); IMG_SIZE byte[34]=0x20.
   -> One 0x00 pad byte after each 15 pixel bytes.
4. Toggle out_ready randomly (50%).
   -> Byte sequence is identical to scenario 1; out_byte stays stable while out_valid && !out_ready.
5. sof after 3 beats of a frame.
   -> frame_err pulse; counters restart; the full frame that follows produces a correct file.
   -> hsync during HEADER is dropped and frame_err pulses.
6. Assert HRESET during PIXELS.
   -> Immediate out_valid=0, in_ready=1, no Write_Done; the next full frame streams correctly.

Source files
------------

// File: rtl/bmp_frame_serializer.sv
// bmp_frame_serializer: captures one RGB888 frame and streams it out as a 24-bit BMP file
module bmp_frame_serializer #(
    parameter int WIDTH        = 100,
    parameter int HEIGHT       = 100,
    parameter int PIX_PER_BEAT = 2
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        hsync,
    input  logic                        sof,
    input  logic [24*PIX_PER_BEAT-1:0]  DATA_IN,
    output logic                        in_ready,
    output logic [7:0]                  out_byte,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        Write_Done,
    output logic                        frame_err
);
    localparam int HEADER_BYTES = 54;
    localparam int ROW_BYTES    = (3*WIDTH + 3) / 4 * 4;
    localparam int IMG_SIZE     = ROW_BYTES * HEIGHT;
    localparam int FILE_SIZE    = HEADER_BYTES + IMG_SIZE;
    localparam int MB           = WIDTH / PIX_PER_BEAT;
    localparam int MW           = $clog2(MB > 1 ? MB : 2);
    localparam int LW           = $clog2(HEIGHT > 1 ? HEIGHT : 2);
    localparam int PW           = $clog2(WIDTH > 1 ? WIDTH : 2);
    localparam int CW           = $clog2(ROW_BYTES + 1);
    localparam int AW           = $clog2(WIDTH*HEIGHT > 1 ? WIDTH*HEIGHT : 2);
    // byte i of the header sits at bits [8i+7:8i]; the top byte is a spare so index 54 stays in range
    localparam logic [439:0] HDR = {8'h00, 32'd0, 32'd0, 32'd2835, 32'd2835, 32'(IMG_SIZE), 32'd0,
                                    16'd24, 16'd1, 32'(HEIGHT), 32'(WIDTH), 32'd40, 32'd54, 32'd0,
                                    32'(FILE_SIZE), 8'h4D, 8'h42};

    typedef enum logic [1:0] {CAPTURE, HEADER, PIXELS} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   m, m_e;
    logic [LW-1:0]   l, l_e, r;
    logic [5:0]      bidx;
    logic [PW-1:0]   p;
    logic [1:0]      k;
    logic [CW-1:0]   c;
    logic [AW-1:0]   waddr, raddr;
    logic [23:0]     mem [WIDTH*HEIGHT];
    logic [23:0]     rd_q;
    logic            accept, first, last_beat, xfer, row_end;

    // handshake decode, capture position, error detection and next state
    always_comb begin
        in_ready  = state_q == CAPTURE;
        accept    = hsync && in_ready;
        first     = accept && sof;
        m_e       = first ? '0 : m;
        l_e       = first ? '0 : l;
        last_beat = l_e == LW'(HEIGHT-1) && m_e == MW'(MB-1);
        frame_err = hsync && (!in_ready || (first && (l != '0 || m != '0)));
        xfer      = out_valid && out_ready;
        row_end   = c == CW'(ROW_BYTES-1);
        waddr     = AW'((HEIGHT-1-int'(l_e))*WIDTH + int'(m_e)*PIX_PER_BEAT);
        raddr     = AW'(int'(r)*WIDTH + int'(p));
        state_d   = state_q;
        if (accept && last_beat) state_d = HEADER;
        if (state_q == HEADER && xfer && bidx == 6'(HEADER_BYTES-1)) state_d = PIXELS;
        if (state_q == PIXELS && xfer && out_last) state_d = CAPTURE;
    end

    // state register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state_q <= CAPTURE;
        else        state_q <= state_d;
    end

    // frame buffer: bottom row first, synchronous read
    always_ff @(posedge HCLK) begin
        if (accept)
            for (int j = 0; j < PIX_PER_BEAT; j++) mem[waddr + AW'(j)] <= DATA_IN[24*j +: 24];
        rd_q <= mem[raddr];
    end

    // capture counters and byte stream; pixel bytes take a load cycle so the buffer read can settle
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            m <= '0; l <= '0; bidx <= '0; p <= '0; k <= '0; c <= '0; r <= '0;
            out_valid <= 1'b0; out_last <= 1'b0; out_byte <= 8'h00; Write_Done <= 1'b0;
        end else begin
            Write_Done <= state_q == PIXELS && xfer && out_last;
            if (accept) begin
                if (last_beat) begin
                    m <= '0; l <= '0; bidx <= '0; p <= '0; k <= '0; c <= '0; r <= '0;
                    out_valid <= 1'b1; out_last <= 1'b0; out_byte <= HDR[7:0];
                end else if (m_e == MW'(MB-1)) begin
                    m <= '0; l <= l_e + 1'b1;
                end else begin
                    m <= m_e + 1'b1; l <= l_e;
                end
            end
            if (state_q == HEADER && xfer) begin
                bidx      <= bidx + 6'd1;
                out_valid <= bidx != 6'(HEADER_BYTES-1);
                out_byte  <= HDR[8*(int'(bidx)+1) +: 8];
            end
            if (state_q == PIXELS) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_last  <= r == LW'(HEIGHT-1) && row_end;
                    out_byte  <= c >= CW'(3*WIDTH) ? 8'h00 : k == 2'd0 ? rd_q[7:0] : k == 2'd1 ? rd_q[15:8] : rd_q[23:16];
                    c <= row_end ? '0 : c + 1'b1;
                    k <= (row_end || k == 2'd2) ? 2'd0 : k + 2'd1;
                    p <= row_end ? '0 : (k == 2'd2 && p != PW'(WIDTH-1)) ? p + 1'b1 : p;
                    if (row_end) r <= r == LW'(HEIGHT-1) ? '0 : r + 1'b1;
                end else if (xfer) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bmp_frame_serializer.sv
// tb_bmp_frame_serializer: directed checks of BMP framing, padding, handshake and error paths
module tb_bmp_frame_serializer;
    logic        HCLK = 0, HRESET;
    logic        hsync_a, sof_a, out_ready_a, in_ready_a, out_valid_a, out_last_a, Write_Done_a, frame_err_a;
    logic [47:0] din_a;
    logic [7:0]  out_byte_a;
    logic        hsync_b, sof_b, out_ready_b, in_ready_b, out_valid_b, out_last_b, Write_Done_b, frame_err_b;
    logic [23:0] din_b;
    logic [7:0]  out_byte_b;
    int          checks = 0, failures = 0;
    logic [7:0]  cap [0:127];
    logic [7:0]  exp_f [0:127];

    typedef struct packed {int idx; logic [7:0] v;} vec_t;
    vec_t va [23];
    vec_t vb [9];

    always #5 HCLK = ~HCLK;

    bmp_frame_serializer #(.WIDTH(4), .HEIGHT(2), .PIX_PER_BEAT(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .hsync(hsync_a), .sof(sof_a), .DATA_IN(din_a),
        .in_ready(in_ready_a), .out_byte(out_byte_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_last(out_last_a), .Write_Done(Write_Done_a), .frame_err(frame_err_a));

    bmp_frame_serializer #(.WIDTH(5), .HEIGHT(2), .PIX_PER_BEAT(1)) dut5 (
        .HCLK(HCLK), .HRESET(HRESET), .hsync(hsync_b), .sof(sof_b), .DATA_IN(din_b),
        .in_ready(in_ready_b), .out_byte(out_byte_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_last(out_last_b), .Write_Done(Write_Done_b), .frame_err(frame_err_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input logic [23:0] b, input int x);
        return 24'(b * (x + 1));
    endfunction

    task automatic put(input int off, input int n, input int val);
        for (int i = 0; i < n; i++) exp_f[off+i] = 8'(val >> (8*i));
    endtask

    task automatic build_exp(input int w, input int h, input logic [23:0] b0, input logic [23:0] b1, output int flen);
        int rowb, o;
        logic [23:0] px;
        rowb = (3*w + 3) / 4 * 4;
        flen = 54 + rowb*h;
        exp_f[0] = 8'h42; exp_f[1] = 8'h4D;
        put(2, 4, flen); put(6, 4, 0); put(10, 4, 54); put(14, 4, 40); put(18, 4, w); put(22, 4, h);
        put(26, 2, 1); put(28, 2, 24); put(30, 4, 0); put(34, 4, rowb*h); put(38, 4, 2835);
        put(42, 4, 2835); put(46, 4, 0); put(50, 4, 0);
        o = 54;
        for (int y = h-1; y >= 0; y--) begin
            for (int x = 0; x < w; x++) begin
                px = pix(y == 0 ? b0 : b1, x);
                exp_f[o] = px[7:0]; exp_f[o+1] = px[15:8]; exp_f[o+2] = px[23:16];
                o += 3;
            end
            for (int q = 3*w; q < rowb; q++) begin exp_f[o] = 8'h00; o++; end
        end
    endtask

    task automatic verify(input string name, input int flen, input int n, input int lastidx);
        int mism, first;
        mism = 0; first = -1;
        for (int i = 0; i < flen && i < 128; i++)
            if (cap[i] !== exp_f[i]) begin mism++; if (first < 0) first = i; end
        chk({name, "_len"}, n, flen);
        chk({name, "_last_idx"}, lastidx, flen - 1);
        chk({name, "_bytes_wrong"}, mism, 0);
        if (mism != 0) $display("  first differing byte %0d: got %0h want %0h", first, cap[first], exp_f[first]);
    endtask

    task automatic beat_a(input logic s, input logic [47:0] d, output logic e, output logic rdy);
        hsync_a = 1; sof_a = s; din_a = d;
        @(negedge HCLK); e = frame_err_a; rdy = in_ready_a;
        @(posedge HCLK); #1;
        hsync_a = 0; sof_a = 0;
    endtask

    task automatic send_a(input logic [23:0] b0, input logic [23:0] b1, output logic e0, output int bad);
        logic e, rdy;
        logic [23:0] b;
        bad = 0; e0 = 0;
        for (int k = 0; k < 4; k++) begin
            b = k < 2 ? b0 : b1;
            beat_a(k == 0, {pix(b, 2*(k%2)+1), pix(b, 2*(k%2))}, e, rdy);
            if (k == 0) e0 = e; else if (e) bad++;
            if (!rdy) bad++;
        end
    endtask

    task automatic collect_a(input bit rnd, input int poke, input int stop_n, output int n, output int lastidx,
                             output logic fv, output logic [7:0] fb, output logic fir, output logic perr,
                             output int stab, output int gap);
        logic pv, pl;
        logic [7:0] pb;
        int idle;
        n = 0; lastidx = -1; stab = 0; gap = 0; pv = 0; pl = 0; pb = 0; idle = 0;
        perr = 0; fv = 0; fb = 0; fir = 1;
        din_a = 48'hDEAD_BEEF_CAFE;
        out_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge HCLK);
            if (cyc == 0) begin fv = out_valid_a; fb = out_byte_a; fir = in_ready_a; end
            if (cyc == poke) perr = frame_err_a;
            if (pv && !(out_valid_a && out_byte_a == pb && out_last_a == pl)) stab++;
            idle = out_valid_a ? 0 : idle + 1;
            if (idle > 1) gap++;
            pv = out_valid_a && !out_ready_a; pb = out_byte_a; pl = out_last_a;
            if (out_valid_a && out_ready_a) begin
                if (n < 128) cap[n] = out_byte_a;
                if (out_last_a) lastidx = n;
                n++;
            end
            if (lastidx >= 0 || n == stop_n) break;
            @(posedge HCLK); #1;
            hsync_a = cyc + 1 == poke;
            out_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        hsync_a = 0;
    endtask

    task automatic finish_a(input string name);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk({name, "_write_done"}, 32'(Write_Done_a), 1);
        chk({name, "_valid_after"}, 32'(out_valid_a), 0);
        chk({name, "_ready_after"}, 32'(in_ready_a), 1);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk({name, "_write_done_pulse"}, 32'(Write_Done_a), 0);
        @(posedge HCLK); #1;
    endtask

    initial begin
        logic e0, fv, fir, perr, e, rdy;
        logic [7:0] fb;
        int bad, n, lastidx, stab, gap, flen;
        va = '{'{0, 8'h42}, '{1, 8'h4D}, '{2, 8'h4E}, '{3, 8'h00}, '{4, 8'h00}, '{5, 8'h00},
               '{10, 8'h36}, '{14, 8'h28}, '{18, 8'h04}, '{22, 8'h02}, '{26, 8'h01}, '{28, 8'h18},
               '{34, 8'h18}, '{38, 8'h13}, '{39, 8'h0B}, '{54, 8'h13}, '{55, 8'h12}, '{56, 8'h11},
               '{57, 8'h26}, '{66, 8'h03}, '{67, 8'h02}, '{68, 8'h01}, '{77, 8'h04}};
        vb = '{'{2, 8'h56}, '{18, 8'h05}, '{34, 8'h20}, '{54, 8'h22}, '{68, 8'hA0}, '{69, 8'h00},
               '{70, 8'h0C}, '{84, 8'h32}, '{85, 8'h00}};
        HRESET = 1; hsync_a = 0; sof_a = 0; din_a = '0; out_ready_a = 1;
        hsync_b = 0; sof_b = 0; din_b = '0; out_ready_b = 1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_in_ready", 32'(in_ready_a), 1);
        chk("rst_out_valid", 32'(out_valid_a), 0);
        chk("rst_out_last", 32'(out_last_a), 0);
        chk("rst_out_byte", 32'(out_byte_a), 0);
        chk("rst_write_done", 32'(Write_Done_a), 0);
        chk("rst_frame_err", 32'(frame_err_a), 0);
        @(posedge HCLK); #1;
        HRESET = 0;

        // plain frame, sink always ready
        send_a(24'h010203, 24'h111213, e0, bad);
        chk("s1_sof_clean_err", 32'(e0), 0);
        chk("s1_beats_bad", bad, 0);
        collect_a(0, -1, -1, n, lastidx, fv, fb, fir, perr, stab, gap);
        chk("s1_first_valid", 32'(fv), 1);
        chk("s1_first_byte", 32'(fb), 8'h42);
        chk("s1_in_ready_hdr", 32'(fir), 0);
        chk("s1_gap", gap, 0);
        build_exp(4, 2, 24'h010203, 24'h111213, flen);
        verify("s1", flen, n, lastidx);
        for (int i = 0; i < 23; i++) chk($sformatf("s1_vec[%0d]", va[i].idx), 32'(cap[va[i].idx]), 32'(va[i].v));
        finish_a("s1");

        // same frame, random backpressure
        send_a(24'h010203, 24'h111213, e0, bad);
        collect_a(1, -1, -1, n, lastidx, fv, fb, fir, perr, stab, gap);
        chk("s4_stable_hold", stab, 0);
        chk("s4_gap", gap, 0);
        verify("s4", flen, n, lastidx);
        finish_a("s4");

        // sof after 3 beats, then hsync dropped during header
        beat_a(1, 48'hFFFFFF_FFFFFF, e, rdy);
        beat_a(0, 48'hEEEEEE_EEEEEE, e, rdy);
        beat_a(0, 48'hDDDDDD_DDDDDD, e, rdy);
        send_a(24'h0A1B2C, 24'h334455, e0, bad);
        chk("s5_sof_err", 32'(e0), 1);
        chk("s5_beats_bad", bad, 0);
        collect_a(0, 10, -1, n, lastidx, fv, fb, fir, perr, stab, gap);
        chk("s5_hdr_hsync_err", 32'(perr), 1);
        build_exp(4, 2, 24'h0A1B2C, 24'h334455, flen);
        verify("s5", flen, n, lastidx);
        finish_a("s5");

        // reset while streaming pixel bytes
        send_a(24'h010203, 24'h111213, e0, bad);
        collect_a(0, -1, 60, n, lastidx, fv, fb, fir, perr, stab, gap);
        chk("s6_bytes_before_rst", n, 60);
        HRESET = 1; #1;
        chk("s6_rst_valid", 32'(out_valid_a), 0);
        chk("s6_rst_in_ready", 32'(in_ready_a), 1);
        @(posedge HCLK); #1;
        HRESET = 0;
        @(negedge HCLK);
        chk("s6_no_write_done", 32'(Write_Done_a), 0);
        chk("s6_valid_idle", 32'(out_valid_a), 0);
        @(posedge HCLK); #1;
        send_a(24'h405060, 24'h708090, e0, bad);
        chk("s6_beats_bad", bad, 0);
        collect_a(0, -1, -1, n, lastidx, fv, fb, fir, perr, stab, gap);
        build_exp(4, 2, 24'h405060, 24'h708090, flen);
        verify("s6", flen, n, lastidx);
        finish_a("s6");

        // 5x2, one pixel per beat: row padding
        for (int k = 0; k < 10; k++) begin
            hsync_b = 1; sof_b = k == 0; din_b = pix(k < 5 ? 24'h0A0B0C : 24'h202122, k % 5);
            @(negedge HCLK);
            chk($sformatf("b_beat%0d_ready", k), 32'(in_ready_b && !frame_err_b), 1);
            @(posedge HCLK); #1;
        end
        hsync_b = 0; sof_b = 0;
        n = 0; lastidx = -1; gap = 0;
        for (int cyc = 0; cyc < 2000 && lastidx < 0; cyc++) begin
            @(negedge HCLK);
            if (out_valid_b) begin
                if (n < 128) cap[n] = out_byte_b;
                if (out_last_b) lastidx = n;
                n++;
            end
            if (lastidx < 0) begin @(posedge HCLK); #1; end
        end
        build_exp(5, 2, 24'h0A0B0C, 24'h202122, flen);
        verify("b", flen, n, lastidx);
        for (int i = 0; i < 9; i++) chk($sformatf("b_vec[%0d]", vb[i].idx), 32'(cap[vb[i].idx]), 32'(vb[i].v));
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("b_write_done", 32'(Write_Done_b), 1);
        chk("b_ready_after", 32'(in_ready_b), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
